mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin access controller that shares a single-write/single-read-port memory array (the `Mem` array style: combinational read, posedge write) between NUM_REQ requesters. After reset it first sweeps the whole array to zero, then grants one transaction per cycle with fair rotation. Read data returns one cycle after acceptance. It sits between client blocks and one memory instance; it is the only driver of that memory's write and read-address ports.

## Interface
Parameters:
- ADDR_SIZE, 4, address width; memory depth is 2**ADDR_SIZE words.
- BYTE_SIZE, 8, data word width.
- NUM_REQ, 4, number of requesters; legal range 2..8.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset; clears all state immediately.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_SIZE  flattened addresses; requester i uses bits [i*ADDR_SIZE +: ADDR_SIZE].
- req_wdata  in  NUM_REQ*BYTE_SIZE  flattened write data, same slicing.
- req_ready  out  NUM_REQ  one-hot (or zero) grant; a transfer fires when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot pulse marking read data for requester i.
- rsp_data  out  BYTE_SIZE  read data, shared by all requesters.
- init_done  out  1  high once the clear sweep has finished.
- mem_wen  out  1  memory write enable.
- mem_waddr  out  ADDR_SIZE  memory write address.
- mem_wdata  out  BYTE_SIZE  memory write data.
- mem_raddr  out  ADDR_SIZE  memory read address.
- mem_rdata  in  BYTE_SIZE  combinational memory read data for mem_raddr.

## Operation
- States: IDLE (reset value), CLEAR, RUN.
- IDLE: all outputs 0 and mem_wen 0. On the first posedge after reset_n rises, go to CLEAR with clear_cnt = 0.
- CLEAR: mem_wen=1, mem_waddr=clear_cnt, mem_wdata=0, req_ready=0. clear_cnt increments each cycle. On the cycle clear_cnt = 2**ADDR_SIZE-1, go to RUN and set init_done=1. The sweep is exactly 2**ADDR_SIZE cycles.
- RUN, arbitration: the winner is the first requester with req_valid set, searching from index ptr upward and wrapping modulo NUM_REQ. req_ready = onehot(winner), or 0 if none valid. req_ready is combinational from req_valid and ptr.
- The pointer only moves when a grant fires: ptr <= winner+1 mod NUM_REQ. With no request, ptr holds.
- Granted write: mem_wen=1 and mem_waddr/mem_wdata come from the winner's slice in the same cycle. No response is generated.
- Granted read: mem_raddr comes from the winner's slice, and mem_wen=0. At the posedge, rsp_data <= mem_rdata and rsp_valid <= onehot(winner).
- rsp_valid holds for exactly one cycle. rsp_data holds its last value until the next read response.
- Outside a granted read, mem_raddr = 0. Outside a write, mem_waddr = 0 and mem_wdata = 0.
- Only one transaction happens per cycle, so read/write collisions to the memory cannot occur.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data, because the write commits at the intervening edge.
- Requesters must hold req_valid/addr/data stable until the transfer fires. A dropped request is legal and simply loses arbitration.
- Reset mid-operation, including mid-CLEAR: the next state is IDLE with ptr=0 and init_done=0. The full sweep re-runs after release, and any in-flight rsp_valid is discarded.

## Timing
- Write latency: committed at the edge ending the grant cycle.
- Read latency: rsp_valid is asserted the cycle after the grant.
- Throughput: 1 transaction per cycle in RUN.
- Worst-case wait for a continuously-valid requester: NUM_REQ-1 grants to others.
- First possible grant: cycle 2**ADDR_SIZE+1 after reset release.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, init_done=0, mem_wen=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, ptr=0, clear_cnt=0, state=IDLE.

## Structure
- Shared package/header mem_arb_pkg:
  - state encodings IDLE=2'd0, CLEAR=2'd1, RUN=2'd2.
  - MAX_NUM_REQ=8.
  - the parameter-legality check.
- Sub-module rr_pick (combinational):
  - inputs: valid[NUM_REQ], ptr.
  - outputs: one-hot grant, winner index, any.
  - reused by future schedulers.
- The FSM, pointer, clear counter, response registers and muxing live in mem_arbiter.

## Test plan
- Reset release, no requests (ADDR_SIZE=4) -> mem_wen high for exactly 16 cycles with waddr 0..15 and wdata 0; init_done rises on cycle 17; req_ready stays 0 throughout.
- All four requesters continuously reading different addresses -> grants rotate 0,1,2,3,0; each rsp_valid pulse is one cycle after its grant; after the clear sweep, rsp_data=0.
- Requester 2 writes 8'hA5 to addr 3, then requester 0 reads addr 3 the next cycle -> rsp_valid=4'b0001 with rsp_data=8'hA5.
- Only requester 1 is valid, then requesters 1 and 3 become valid -> 1 is granted, then 3 next (ptr=2 skips to 3), then 1 again.
- reset_n pulsed low mid-CLEAR (clear_cnt=7) -> all outputs 0 immediately; after release the sweep restarts at address 0 and runs the full 16 cycles.
- reset_n pulsed low on the edge where a read response is pending -> rsp_valid never asserts and ptr returns to 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state encoding and parameter helpers for the memory arbiter and its pickers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } arb_state_e;

    localparam int unsigned MIN_NUM_REQ = 2;
    localparam int unsigned MAX_NUM_REQ = 8;

    function automatic bit num_req_legal(input int unsigned n);
        return (n >= MIN_NUM_REQ) && (n <= MAX_NUM_REQ);
    endfunction

    // Width of an index into n requesters; never zero.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);

    int unsigned idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && valid[PTR_W'(idx)]) begin
                any                = 1'b1;
                winner             = PTR_W'(idx);
                grant[PTR_W'(idx)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin access controller for a single-write/single-read-port memory.
// Clears the array after reset, then grants one transaction per cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned BYTE_SIZE = 8,
    parameter int unsigned NUM_REQ   = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*BYTE_SIZE-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [BYTE_SIZE-1:0]           rsp_data,
    output logic                           init_done,
    output logic                           mem_wen,
    output logic [ADDR_SIZE-1:0]           mem_waddr,
    output logic [BYTE_SIZE-1:0]           mem_wdata,
    output logic [ADDR_SIZE-1:0]           mem_raddr,
    input  logic [BYTE_SIZE-1:0]           mem_rdata
);

    localparam int unsigned PTR_W = idx_width(NUM_REQ);
    localparam int unsigned DEPTH = 1 << ADDR_SIZE;

    if (!num_req_legal(NUM_REQ)) begin : g_bad_num_req
        $error("mem_arbiter: NUM_REQ must be within 2..8");
    end

    arb_state_e             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [ADDR_SIZE-1:0]   clear_cnt_q, clear_cnt_d;
    logic                   init_done_q, init_done_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [BYTE_SIZE-1:0]   rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [PTR_W-1:0]       pick_winner;
    logic                   pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .valid  (req_valid),
        .ptr    (ptr_q),
        .grant  (pick_grant),
        .winner (pick_winner),
        .any    (pick_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            clear_cnt_q <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            clear_cnt_q <= clear_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state, pointer rotation and memory port muxing.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        clear_cnt_d = clear_cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        req_ready   = '0;
        mem_wen     = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        mem_raddr   = '0;

        case (state_q)
            IDLE: begin
                state_d     = CLEAR;
                clear_cnt_d = '0;
                init_done_d = 1'b0;
            end
            CLEAR: begin
                mem_wen     = 1'b1;
                mem_waddr   = clear_cnt_q;
                clear_cnt_d = clear_cnt_q + ADDR_SIZE'(1);
                if (clear_cnt_q == ADDR_SIZE'(DEPTH - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                req_ready = pick_grant;
                if (pick_any) begin
                    // Explicit wrap keeps the pointer legal for non-power-of-two NUM_REQ.
                    if (32'(pick_winner) == NUM_REQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = pick_winner + PTR_W'(1);
                    end
                    if (req_we[pick_winner]) begin
                        mem_wen   = 1'b1;
                        mem_waddr = req_addr[32'(pick_winner) * ADDR_SIZE +: ADDR_SIZE];
                        mem_wdata = req_wdata[32'(pick_winner) * BYTE_SIZE +: BYTE_SIZE];
                    end else begin
                        mem_raddr   = req_addr[32'(pick_winner) * ADDR_SIZE +: ADDR_SIZE];
                        rsp_valid_d = pick_grant;
                        rsp_data_d  = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural memory array.
module tb_mem_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              init_done;
    logic              mem_wen;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic [AW-1:0]     mem_raddr;
    logic [DW-1:0]     mem_rdata;

    logic [DW-1:0]     mem [16] = '{default: 8'hC3};

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_raddr];

    mem_arbiter #(
        .ADDR_SIZE (AW),
        .BYTE_SIZE (DW),
        .NUM_REQ   (NR)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic test_reset();
        int nonzero;
        clear_reqs();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_data, init_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b rsp_data=%h init_done=%b expected all 0",
                     req_ready, rsp_valid, rsp_data, init_done);
        end
        tests_run++;
        if ({mem_wen, mem_waddr, mem_wdata, mem_raddr} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mem_port: wen=%b waddr=%h wdata=%h raddr=%h expected all 0",
                     mem_wen, mem_waddr, mem_wdata, mem_raddr);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < int'(NR); i++) set_req(i, 1'b1, 1'b0, AW'(i), 8'h00);
        #1;
        tests_run++;
        if ({mem_wen, init_done, req_ready} !== 6'b0) begin
            tests_failed++;
            $display("FAIL idle_after_release: wen=%b init_done=%b ready=%b expected 0,0,0000",
                     mem_wen, init_done, req_ready);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            #1;
            tests_run++;
            if ({mem_wen, mem_waddr, mem_wdata, req_ready, init_done} !==
                {1'b1, AW'(k), 8'h00, 4'b0000, 1'b0}) begin
                tests_failed++;
                $display("FAIL sweep_cycle_%0d: wen=%b waddr=%0d wdata=%h ready=%b init_done=%b expected 1,%0d,00,0000,0",
                         k, mem_wen, mem_waddr, mem_wdata, req_ready, init_done, k);
            end
        end
        @(negedge clock);
        clear_reqs();
        #1;
        tests_run++;
        if ({init_done, mem_wen, req_ready} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL sweep_done: init_done=%b wen=%b ready=%b expected 1,0,0000",
                     init_done, mem_wen, req_ready);
        end
        nonzero = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 8'h00) nonzero++;
        tests_run++;
        if (nonzero != 0) begin
            tests_failed++;
            $display("FAIL sweep_cleared: %0d nonzero words expected 0", nonzero);
        end
    endtask

    task automatic test_rotation();
        logic [NR-1:0] exp_g;
        logic [NR-1:0] prev_g;
        prev_g = '0;
        @(negedge clock);
        for (int i = 0; i < int'(NR); i++) set_req(i, 1'b1, 1'b0, AW'(i + 4), 8'h00);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clock);
            #1;
            exp_g = NR'(1 << (s % 4));
            tests_run++;
            if (req_ready !== exp_g || mem_raddr !== AW'((s % 4) + 4) || mem_wen !== 1'b0) begin
                tests_failed++;
                $display("FAIL rotate_grant_%0d: ready=%b raddr=%0d wen=%b expected %b,%0d,0",
                         s, req_ready, mem_raddr, mem_wen, exp_g, (s % 4) + 4);
            end
            tests_run++;
            if (rsp_valid !== prev_g || rsp_data !== 8'h00) begin
                tests_failed++;
                $display("FAIL rotate_rsp_%0d: rsp_valid=%b rsp_data=%h expected %b,00",
                         s, rsp_valid, rsp_data, prev_g);
            end
            prev_g = exp_g;
        end
        @(negedge clock);
        clear_reqs();
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0001 || req_ready !== 4'b0000 || mem_raddr !== 4'd0) begin
            tests_failed++;
            $display("FAIL rotate_last_rsp: rsp_valid=%b ready=%b raddr=%0d expected 0001,0000,0",
                     rsp_valid, req_ready, mem_raddr);
        end
        @(negedge clock);
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rsp_one_cycle: rsp_valid=%b expected 0000", rsp_valid);
        end
    endtask

    task automatic test_raw();
        @(negedge clock);
        set_req(2, 1'b1, 1'b1, 4'd3, 8'hA5);
        #1;
        tests_run++;
        if ({req_ready, mem_wen, mem_waddr, mem_wdata, mem_raddr} !==
            {4'b0100, 1'b1, 4'd3, 8'hA5, 4'd0}) begin
            tests_failed++;
            $display("FAIL raw_write: ready=%b wen=%b waddr=%0d wdata=%h raddr=%0d expected 0100,1,3,a5,0",
                     req_ready, mem_wen, mem_waddr, mem_wdata, mem_raddr);
        end
        @(negedge clock);
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        tests_run++;
        if ({req_ready, mem_wen, mem_waddr, mem_wdata, mem_raddr} !==
            {4'b0001, 1'b0, 4'd0, 8'h00, 4'd3}) begin
            tests_failed++;
            $display("FAIL raw_read: ready=%b wen=%b waddr=%0d wdata=%h raddr=%0d expected 0001,0,0,00,3",
                     req_ready, mem_wen, mem_waddr, mem_wdata, mem_raddr);
        end
        @(negedge clock);
        clear_reqs();
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL raw_rsp: rsp_valid=%b rsp_data=%h expected 0001,a5", rsp_valid, rsp_data);
        end
        @(negedge clock);
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL rsp_data_hold: rsp_valid=%b rsp_data=%h expected 0000,a5", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_skip();
        logic [NR-1:0] exp_seq [5];
        exp_seq = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b1000};
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            clear_reqs();
            if (s == 0 || s == 1 || s == 2 || s == 4) set_req(1, 1'b1, 1'b0, 4'd1, 8'h00);
            if (s == 1 || s == 2 || s == 4) set_req(3, 1'b1, 1'b0, 4'd2, 8'h00);
            #1;
            tests_run++;
            if (req_ready !== exp_seq[s]) begin
                tests_failed++;
                $display("FAIL skip_step_%0d: ready=%b expected %b", s, req_ready, exp_seq[s]);
            end
        end
        @(negedge clock);
        clear_reqs();
    endtask

    task automatic test_reset_mid_clear();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({rsp_valid, req_ready, init_done, mem_wen} !== 10'b0) begin
            tests_failed++;
            $display("FAIL run_reset: rsp_valid=%b ready=%b init_done=%b wen=%b expected all 0",
                     rsp_valid, req_ready, init_done, mem_wen);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (8) @(negedge clock);
        #1;
        tests_run++;
        if (mem_wen !== 1'b1 || mem_waddr !== 4'd7) begin
            tests_failed++;
            $display("FAIL mid_clear_pos: wen=%b waddr=%0d expected 1,7", mem_wen, mem_waddr);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_wen, mem_waddr, mem_wdata, init_done, req_ready} !== '0) begin
            tests_failed++;
            $display("FAIL mid_clear_reset: wen=%b waddr=%0d wdata=%h init_done=%b ready=%b expected all 0",
                     mem_wen, mem_waddr, mem_wdata, init_done, req_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            #1;
            tests_run++;
            if ({mem_wen, mem_waddr, mem_wdata, init_done} !== {1'b1, AW'(k), 8'h00, 1'b0}) begin
                tests_failed++;
                $display("FAIL resweep_cycle_%0d: wen=%b waddr=%0d wdata=%h init_done=%b expected 1,%0d,00,0",
                         k, mem_wen, mem_waddr, mem_wdata, init_done, k);
            end
        end
        @(negedge clock);
        #1;
        tests_run++;
        if (init_done !== 1'b1 || mem_wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL resweep_done: init_done=%b wen=%b expected 1,0", init_done, mem_wen);
        end
    endtask

    task automatic test_reset_pending_rsp();
        @(negedge clock);
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 4'd0, 8'h00);
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL pend_pre_grant: ready=%b expected 0010", req_ready);
        end
        @(negedge clock);
        clear_reqs();
        set_req(2, 1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        tests_run++;
        if (req_ready !== 4'b0100 || mem_raddr !== 4'd3) begin
            tests_failed++;
            $display("FAIL pend_grant: ready=%b raddr=%0d expected 0100,3", req_ready, mem_raddr);
        end
        #2 reset_n = 1'b0;
        @(negedge clock);
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL pend_discard: rsp_valid=%b ready=%b expected 0000,0000", rsp_valid, req_ready);
        end
        reset_n = 1'b1;
        for (int i = 0; i < int'(NR); i++) set_req(i, 1'b1, 1'b0, AW'(i), 8'h00);
        for (int k = 0; k < 17; k++) begin
            @(negedge clock);
            #1;
            tests_run++;
            if (rsp_valid !== 4'b0000) begin
                tests_failed++;
                $display("FAIL pend_quiet_%0d: rsp_valid=%b expected 0000", k, rsp_valid);
            end
        end
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL ptr_after_reset: ready=%b expected 0001", req_ready);
        end
        @(negedge clock);
        clear_reqs();
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0001) begin
            tests_failed++;
            $display("FAIL first_rsp_after_reset: rsp_valid=%b expected 0001", rsp_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_reqs();
        test_reset();
        test_rotation();
        test_raw();
        test_skip();
        test_reset_mid_clear();
        test_reset_pending_rsp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
